spart_receive: RTL
==================

Name: spart_receive

Overview:
- Receive half of the SPART: recovers 8N1 asynchronous serial frames from the rxd pin.
- Uses the baud-rate generator's oversampling enable to time bit sampling.
- Presents each received byte to the processor-side bus interface, with a data-available flag and error status.
- Sits beside the transmit block and shares the same iocs/iorw/ioaddr decode; the top-level bus mux drives the databus from rx_data and status.

Parameters:
- OVERSAMPLE, 16, brg_en ticks per bit period; must be even and at least 4.
- DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- brg_en  input  1  one-clk-wide oversample tick from the baud-rate generator, OVERSAMPLE ticks per bit
- rxd  input  1  serial line, asynchronous to clk; idle high
- iocs  input  1  chip select
- iorw  input  1  1 = read, 0 = write
- ioaddr  input  2  register address; 2'd0 = receive data, 2'd1 = status
- rx_data  output  DATA_BITS  last completed byte
- rda  output  1  receive data available
- framing_err  output  1  sticky: stop bit was sampled low
- overrun  output  1  sticky: a new byte completed while rda was still 1

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - rx_data=0, rda=0, framing_err=0, overrun=0.
  - FSM goes to IDLE; tick and bit counters go to 0.
  - Both synchronizer flops go to 1.
- Input synchronizer: rxd passes through 2 flops to give rxd_s. All decisions use rxd_s only.
- FSM state IDLE:
  - Leaves only on a falling edge of rxd_s (previous rxd_s=1, current rxd_s=0), evaluated every clk regardless of brg_en.
  - On that edge: go to START, clear the tick counter.
  - A line held low (break, or low after a framing error) does not retrigger until rxd_s returns high.
- FSM state START:
  - Counts brg_en ticks. On the tick that brings the count to OVERSAMPLE/2, sample rxd_s.
  - rxd_s=0: go to DATA, clear tick counter and bit counter.
  - rxd_s=1: false start; return to IDLE with no flags changed.
- FSM state DATA:
  - Counts brg_en ticks. On every OVERSAMPLE-th tick (mid-bit), shift rxd_s into the MSB of the shift register (right shift, LSB arrives first) and increment the bit counter.
  - After DATA_BITS samples: go to STOP, clear tick counter.
- FSM state STOP:
  - On the OVERSAMPLE-th tick, sample rxd_s, then return to IDLE.
  - rxd_s=1 (valid frame): on the next clk edge, rx_data <= shift register and rda <= 1. If rda was already 1 and not being cleared in that same cycle, overrun <= 1 and the new byte overwrites rx_data.
  - rxd_s=0: framing_err <= 1. rx_data and rda are unchanged; the byte is discarded.
- Ticks: brg_en low means counters hold. Ticks only advance counters in START, DATA and STOP.
- Data read: a cycle with iocs & iorw & ioaddr==2'd0 clears rda on the next edge. rx_data is held, not cleared.
- Status read: a cycle with iocs & iorw & ioaddr==2'd1 clears framing_err and overrun on the next edge.
- Simultaneous events:
  - Data read in the same cycle as a valid frame completing: the new byte wins. rda stays 1, rx_data updates, overrun is not set.
  - Status read in the same cycle as a new error being set: set wins.
- Writes (iorw=0) are ignored by this block.
- Latency: rda rises 1 clk after the brg_en tick that samples the stop bit. End to end from the rxd falling edge this is about 2 + (OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE) ticks.

Test Plan:
- Valid frame: brg_en tied to 1, send 0xA5 8N1 at 16 clk/bit -> rda rises 1 clk after the stop-bit mid-sample; rx_data=8'hA5; framing_err=0; overrun=0. A data read then clears rda the next cycle, with rx_data still 8'hA5.
- Glitch: 5-clk low pulse on an idle line -> FSM returns to IDLE; rda, framing_err and rx_data unchanged. A following 0x3C frame is received correctly.
- Framing error: send 0x55 with the stop bit driven 0 -> framing_err=1, rda=0, rx_data keeps its previous value. Holding rxd low for 100 clk produces no new frame. A status read clears framing_err.
- Overrun: send 0x11 then 0x22 back to back with no read -> rx_data=8'h22, rda=1, overrun=1. Repeat with a data read landing exactly on the completion cycle of 0x22 -> overrun=0, rda=1.
- Reset mid-frame: assert rst asynchronously (between clk edges) during data bit 4 of 0xF0 -> all outputs 0 immediately. After release, a clean 0x81 frame is received with rx_data=8'h81.
- Sparse ticks: brg_en pulses every 4th clk, send 0xC3 at 64 clk/bit -> rx_data=8'hC3. Counters hold on non-tick cycles.

Source files
------------

// File: rtl/spart_receive_if.sv
// rtl/spart_receive_if.sv - processor-side register bus of the SPART receiver
interface spart_receive_if #(
    parameter int DATA_BITS = 8
);
    logic                 iocs;
    logic                 iorw;
    logic [1:0]           ioaddr;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 framing_err;
    logic                 overrun;

    modport master (
        output iocs, iorw, ioaddr,
        input  rx_data, rda, framing_err, overrun
    );

    modport slave (
        input  iocs, iorw, ioaddr,
        output rx_data, rda, framing_err, overrun
    );
endinterface

// File: rtl/spart_receive.sv
// rtl/spart_receive.sv - SPART receiver: oversampled 8N1 frame recovery with rda/error status
module spart_receive #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           brg_en,
    input  logic           rxd,
    spart_receive_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 rxd_prev_q, rxd_prev_d;
    logic [1:0]           state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rda_q, rda_d;
    logic                 framing_err_q, framing_err_d;
    logic                 overrun_q, overrun_d;

    logic                 rxd_s;
    logic [TW-1:0]        tick_inc;
    logic [BW-1:0]        bit_inc;
    logic                 data_rd;
    logic                 stat_rd;
    logic                 frame_ok;
    logic                 frame_bad;

    assign rxd_s    = sync2_q;
    assign tick_inc = tick_q + TW'(1);
    assign bit_inc  = bit_q + BW'(1);
    assign data_rd  = bus.iocs & bus.iorw & (bus.ioaddr == 2'd0);
    assign stat_rd  = bus.iocs & bus.iorw & (bus.ioaddr == 2'd1);

    always_comb begin
        sync1_d    = rxd;
        sync2_d    = sync1_q;
        rxd_prev_d = rxd_s;
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;

        case (state_q)
            IDLE: begin
                // Edge-only trigger: a line parked low never restarts a frame.
                if (rxd_prev_q && !rxd_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (brg_en) begin
                    tick_d = tick_inc;
                    if (tick_inc == TICK_HALF) begin
                        if (!rxd_s) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (brg_en) begin
                    tick_d = tick_inc;
                    if (tick_inc == TICK_FULL) begin
                        tick_d  = '0;
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_inc;
                        if (bit_inc == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (brg_en) begin
                    tick_d = tick_inc;
                    if (tick_inc == TICK_FULL) begin
                        state_d   = IDLE;
                        tick_d    = '0;
                        frame_ok  = rxd_s;
                        frame_bad = !rxd_s;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completing frame outranks a same-cycle clear; error set outranks status clear.
    always_comb begin
        rx_data_d     = frame_ok ? shift_q : rx_data_q;
        rda_d         = rda_q;
        framing_err_d = framing_err_q;
        overrun_d     = overrun_q;
        if (data_rd)  rda_d = 1'b0;
        if (frame_ok) rda_d = 1'b1;
        if (stat_rd) begin
            framing_err_d = 1'b0;
            overrun_d     = 1'b0;
        end
        if (frame_bad) framing_err_d = 1'b1;
        if (frame_ok && rda_q && !data_rd) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rxd_prev_q    <= 1'b1;
            state_q       <= IDLE;
            tick_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rda_q         <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            rxd_prev_q    <= rxd_prev_d;
            state_q       <= state_d;
            tick_q        <= tick_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rda_q         <= rda_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rda         = rda_q;
    assign bus.framing_err = framing_err_q;
    assign bus.overrun     = overrun_q;
endmodule
